// File: rtl/csr_access_arbiter_if.sv
// csr_access_arbiter_if: requester bus (req/payload/redirect in, gnt/resp out) with master and slave modports
interface csr_access_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64,
  parameter int ROB_W = 6
);
  logic [2:0] req;
  logic [2:0][ADDR_W-1:0] req_addr;
  logic [2:0] req_wen;
  logic [2:0][DATA_W-1:0] req_wdata;
  logic [ROB_W:0] issue_rob_idx;
  logic redirect;
  logic [ROB_W:0] redirect_idx;
  logic [2:0] gnt;
  logic [2:0] resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic resp_flush;
  logic resp_exc;
  modport master (
    output req, req_addr, req_wen, req_wdata, issue_rob_idx, redirect, redirect_idx,
    input gnt, resp_valid, resp_data, resp_flush, resp_exc
  );
  modport slave (
    input req, req_addr, req_wen, req_wdata, issue_rob_idx, redirect, redirect_idx,
    output gnt, resp_valid, resp_data, resp_flush, resp_exc
  );
endinterface

// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter: shares the CSR file port among trap/issue/debug via 2-cycle read-modify-write; ports clk, rst, bus (slave), csr_* file port
module csr_access_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64,
  parameter int ROB_W = 6,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  csr_access_arbiter_if.slave bus,
  output logic csr_en_o,
  output logic csr_wen_o,
  output logic [ADDR_W-1:0] csr_addr_o,
  output logic [DATA_W-1:0] csr_wdata_o,
  input  logic [DATA_W-1:0] csr_rdata_i,
  input  logic csr_illegal_i
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, COMMIT} state_t;
  state_t state_q, state_d;
  logic [1:0] owner_q, owner_d, win;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ROB_W:0] rob_q, rob_d;
  logic cancel_q, cancel_d;
  logic exc_q, exc_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [2:0] elig;
  logic grant, older, squash, kill, wr, access, commit;
  assign access = state_q == ACCESS;
  assign commit = state_q == COMMIT;
  // wrap-around age compare: a direction-bit mismatch means the index wrapped
  assign older = (rob_q[ROB_W] == bus.redirect_idx[ROB_W]) ?
                 rob_q[ROB_W-1:0] < bus.redirect_idx[ROB_W-1:0] :
                 rob_q[ROB_W-1:0] > bus.redirect_idx[ROB_W-1:0];
  assign squash = owner_q == 2'd1 && bus.redirect && !older;
  assign kill = commit && squash;
  assign wr = wen_q && !exc_q && !cancel_q && !kill;
  assign elig = bus.req & {1'b1, ~bus.redirect, 1'b1};
  assign win = elig[0] ? 2'd0 :
               (starve_q == CNT_W'(STARVE_LIMIT)) ? (elig[2] ? 2'd2 : 2'd1) :
               (elig[1] ? 2'd1 : 2'd2);
  assign grant = !access && |elig;
  always_comb begin
    state_d = grant ? ACCESS : (access ? COMMIT : IDLE);
    owner_d = grant ? win : owner_q;
    addr_d = grant ? bus.req_addr[win] : addr_q;
    wen_d = grant ? bus.req_wen[win] : wen_q;
    wdata_d = grant ? bus.req_wdata[win] : wdata_q;
    rob_d = grant ? bus.issue_rob_idx : rob_q;
    cancel_d = access ? squash : cancel_q;
    exc_d = access ? csr_illegal_i : exc_q;
    rdata_d = access ? csr_rdata_i : rdata_q;
    starve_d = (!bus.req[2] || bus.gnt[2]) ? '0 :
               (starve_q == CNT_W'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      addr_q <= '0;
      wen_q <= 1'b0;
      wdata_q <= '0;
      rob_q <= '0;
      cancel_q <= 1'b0;
      exc_q <= 1'b0;
      rdata_q <= '0;
      starve_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q <= addr_d;
      wen_q <= wen_d;
      wdata_q <= wdata_d;
      rob_q <= rob_d;
      cancel_q <= cancel_d;
      exc_q <= exc_d;
      rdata_q <= rdata_d;
      starve_q <= starve_d;
    end
  end
  assign bus.gnt = grant ? 3'b001 << win : 3'b000;
  assign bus.resp_valid = commit ? 3'b001 << owner_q : 3'b000;
  assign bus.resp_data = commit ? rdata_q : '0;
  assign bus.resp_exc = commit && exc_q;
  assign bus.resp_flush = commit && (cancel_q || kill);
  assign csr_en_o = access || (commit && wr);
  assign csr_wen_o = commit && wr;
  assign csr_addr_o = (access || commit) ? addr_q : '0;
  assign csr_wdata_o = commit ? wdata_q : '0;
endmodule

// File: tb/tb_csr_access_arbiter.sv
// tb_csr_access_arbiter: directed scoreboard bench for csr_access_arbiter
module tb_csr_access_arbiter;
  localparam int AW = 12, DW = 64, RW = 6, SL = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  csr_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ROB_W(RW)) bus();
  logic csr_en, csr_wen, csr_illegal;
  logic [AW-1:0] csr_addr;
  logic [DW-1:0] csr_wdata, csr_rdata;
  logic [DW-1:0] mem [0:4095];
  assign csr_rdata = mem[csr_addr];
  assign csr_illegal = csr_addr == 12'hFFF;
  always @(posedge clk) if (csr_wen) mem[csr_addr] <= csr_wdata;
  csr_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROB_W(RW), .STARVE_LIMIT(SL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .csr_en_o(csr_en),
    .csr_wen_o(csr_wen),
    .csr_addr_o(csr_addr),
    .csr_wdata_o(csr_wdata),
    .csr_rdata_i(csr_rdata),
    .csr_illegal_i(csr_illegal)
  );
  typedef struct packed {
    logic [1:0] owner;
    logic [DW-1:0] data;
    logic exc, flush, wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, failures = 0;
  logic [2:0] eg;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, want);
    end
  endtask
  task automatic push(input logic [1:0] o, input logic [DW-1:0] d, input logic x, input logic f,
                      input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    sb.push_back('{owner: o, data: d, exc: x, flush: f, wr: w, addr: a, wdata: wd});
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic setreq(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    bus.req[i] = 1'b1;
    bus.req_addr[i] = a;
    bus.req_wen[i] = w;
    bus.req_wdata[i] = d;
  endtask
  always @(negedge clk) begin
    if (!rst && |bus.resp_valid) begin
      if (sb.size() == 0) chk("unexpected_resp", 64'(bus.resp_valid), 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("resp_valid", 64'(bus.resp_valid), 64'(3'b001 << mon_e.owner));
        chk("resp_data", bus.resp_data, mon_e.data);
        chk("resp_exc", 64'(bus.resp_exc), 64'(mon_e.exc));
        chk("resp_flush", 64'(bus.resp_flush), 64'(mon_e.flush));
        chk("csr_wen", 64'(csr_wen), 64'(mon_e.wr));
        if (mon_e.wr) begin
          chk("csr_addr", 64'(csr_addr), 64'(mon_e.addr));
          chk("csr_wdata", csr_wdata, mon_e.wdata);
        end
      end
    end
  end
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem['h300] = 64'h1800;
    mem['h341] = 64'hAAA;
    mem['h305] = 64'h77;
    mem['h306] = 64'h99;
    mem['h307] = 64'h2;
    mem['h7B0] = 64'hD;
    mem['h342] = 64'h11;
    mem['h308] = 64'h3;
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_wen = '0;
    bus.req_wdata = '0;
    bus.issue_rob_idx = '0;
    bus.redirect = 1'b0;
    bus.redirect_idx = '0;
    repeat (3) tick;
    @(negedge clk);
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_csr_en", 64'(csr_en), 64'd0);
    chk("rst_csr_wen", 64'(csr_wen), 64'd0);
    tick;
    rst = 1'b0;
    tick;
    setreq(1, 'h300, 1'b1, 64'h8);
    bus.issue_rob_idx = 7'h05;
    @(negedge clk);
    chk("t1_gnt", 64'(bus.gnt), 64'b010);
    push(2'd1, 64'h1800, 1'b0, 1'b0, 1'b1, 'h300, 64'h8);
    tick;
    bus.req = '0;
    @(negedge clk);
    chk("t1_csr_en", 64'(csr_en), 64'd1);
    chk("t1_read_no_wen", 64'(csr_wen), 64'd0);
    chk("t1_read_addr", 64'(csr_addr), 64'h300);
    tick;
    tick;
    chk("t1_mem", mem['h300], 64'h8);
    tick;
    setreq(0, 'h341, 1'b1, 64'h100);
    setreq(1, 'h300, 1'b0, 64'h0);
    @(negedge clk);
    chk("t2_gnt_trap", 64'(bus.gnt), 64'b001);
    push(2'd0, 64'hAAA, 1'b0, 1'b0, 1'b1, 'h341, 64'h100);
    tick;
    bus.req[0] = 1'b0;
    @(negedge clk);
    chk("t2_gnt_access", 64'(bus.gnt), 64'b000);
    tick;
    @(negedge clk);
    chk("t2_gnt_issue", 64'(bus.gnt), 64'b010);
    push(2'd1, 64'h8, 1'b0, 1'b0, 1'b0, '0, '0);
    tick;
    bus.req = '0;
    tick;
    tick;
    chk("t2_mem", mem['h341], 64'h100);
    tick;
    setreq(1, 'h305, 1'b1, 64'h55);
    bus.issue_rob_idx = 7'h05;
    @(negedge clk);
    chk("t3a_gnt", 64'(bus.gnt), 64'b010);
    push(2'd1, 64'h77, 1'b0, 1'b1, 1'b0, '0, '0);
    tick;
    bus.req = '0;
    bus.redirect = 1'b1;
    bus.redirect_idx = 7'h03;
    tick;
    bus.redirect = 1'b0;
    tick;
    chk("t3a_mem", mem['h305], 64'h77);
    tick;
    setreq(1, 'h306, 1'b1, 64'h66);
    bus.issue_rob_idx = 7'h3C;
    @(negedge clk);
    chk("t3b_gnt", 64'(bus.gnt), 64'b010);
    push(2'd1, 64'h99, 1'b0, 1'b0, 1'b1, 'h306, 64'h66);
    tick;
    bus.req = '0;
    bus.redirect = 1'b1;
    bus.redirect_idx = 7'h42;
    tick;
    tick;
    bus.redirect = 1'b0;
    chk("t3b_mem", mem['h306], 64'h66);
    tick;
    setreq(1, 'h307, 1'b1, 64'h1);
    bus.issue_rob_idx = 7'h05;
    @(negedge clk);
    chk("t3c_gnt", 64'(bus.gnt), 64'b010);
    push(2'd1, 64'h2, 1'b0, 1'b1, 1'b0, '0, '0);
    tick;
    bus.req = '0;
    tick;
    bus.redirect = 1'b1;
    bus.redirect_idx = 7'h05;
    tick;
    bus.redirect = 1'b0;
    chk("t3c_mem", mem['h307], 64'h2);
    tick;
    setreq(1, 'h300, 1'b0, 64'h0);
    setreq(2, 'h7B0, 1'b0, 64'h0);
    for (int i = 0; i <= 10; i++) begin
      eg = (i == 8) ? 3'b100 : (i % 2 == 0) ? 3'b010 : 3'b000;
      @(negedge clk);
      chk($sformatf("t4_gnt_c%0d", i), 64'(bus.gnt), 64'(eg));
      if (eg == 3'b010) push(2'd1, 64'h8, 1'b0, 1'b0, 1'b0, '0, '0);
      else if (eg == 3'b100) push(2'd2, 64'hD, 1'b0, 1'b0, 1'b0, '0, '0);
      tick;
    end
    bus.req = '0;
    tick;
    tick;
    setreq(1, 'hFFF, 1'b1, 64'h1);
    @(negedge clk);
    chk("t5_gnt", 64'(bus.gnt), 64'b010);
    push(2'd1, 64'h0, 1'b1, 1'b0, 1'b0, '0, '0);
    tick;
    bus.req = '0;
    tick;
    tick;
    chk("t5_mem", mem['hFFF], 64'h0);
    setreq(0, 'h342, 1'b1, 64'h22);
    bus.redirect = 1'b1;
    bus.redirect_idx = 7'h00;
    @(negedge clk);
    chk("t5b_gnt", 64'(bus.gnt), 64'b001);
    push(2'd0, 64'h11, 1'b0, 1'b0, 1'b1, 'h342, 64'h22);
    tick;
    bus.req = '0;
    tick;
    tick;
    bus.redirect = 1'b0;
    chk("t5b_mem", mem['h342], 64'h22);
    setreq(1, 'h300, 1'b0, 64'h0);
    bus.redirect = 1'b1;
    @(negedge clk);
    chk("t6_gnt_blocked", 64'(bus.gnt), 64'b000);
    tick;
    @(negedge clk);
    chk("t6_gnt_still_idle", 64'(bus.gnt), 64'b000);
    tick;
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("t6_gnt", 64'(bus.gnt), 64'b010);
    push(2'd1, 64'h8, 1'b0, 1'b0, 1'b0, '0, '0);
    tick;
    bus.req = '0;
    tick;
    tick;
    setreq(1, 'h308, 1'b1, 64'h5);
    @(negedge clk);
    chk("t7_gnt", 64'(bus.gnt), 64'b010);
    tick;
    bus.req = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("t7_no_resp", 64'(bus.resp_valid), 64'd0);
    chk("t7_no_wen", 64'(csr_wen), 64'd0);
    tick;
    chk("t7_mem", mem['h308], 64'h3);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
